sum_accumulator: RTL and testbench

Downstream consumer of the registered adder: it takes the adder's (W+1)-bit `out` result and sums N consecutive results into one frame total. The total is presented on a valid/ready output port. Accepted samples are added with saturation. A sticky overflow flag marks any frame that clipped. This block turns the adder into a multi-operand reduction stage.

---
 rtl/sum_accumulator.sv | 106 ++++++++++
 tb/tb_sum_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums N consecutive adder results into one saturated frame
// total. Each finished frame is offered on a valid/ready output port. A sticky
// overflow flag marks any frame that clipped at 2^ACC_W - 1.
module sum_accumulator #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int ACC_W = 12,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W:0]       in_sum,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    // Count value of the last sample in a frame.
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] sat_sum;

    logic             in_fire;
    logic             out_fire;
    logic             frame_end;

    // A sample may enter whenever the output slot is empty or is being drained
    // this same cycle, so frame boundaries cost no bubble.
    assign in_ready  = ~out_valid | out_ready;
    // clear drops any sample presented with it, even though in_ready follows
    // the normal formula.
    assign in_fire   = in_valid & in_ready & ~clear;
    assign frame_end = in_fire & (count == LAST);
    assign out_fire  = out_valid & out_ready;

    // Saturating add of the zero-extended sample into the running total.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; assigning
        // them up front is what keeps a latch from being inferred.
        sum_ext = '0;
        carry   = 1'b0;
        sat_sum = '0;
        sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_sum);
        carry   = sum_ext[ACC_W];
        sat_sum = carry ? '1 : sum_ext[ACC_W-1:0];
    end

    // Running frame state: partial total, sticky overflow and sample count.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (in_fire) begin
            if (frame_end) begin
                acc   <= '0;
                ovf   <= 1'b0;
                count <= '0;
            end else begin
                acc   <= sat_sum;
                ovf   <= ovf | carry;
                count <= count + CW'(1);
            end
        end
    end

    // Output register: loads only when a frame completes, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else if (frame_end) begin
            out_acc <= sat_sum;
            out_ovf <= ovf | carry;
        end
    end

    // Output valid: a completing frame wins over a drain in the same cycle,
    // so back-to-back frames keep valid high without losing either one.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (frame_end) begin
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (N=4/ACC_W=12, N=4/ACC_W=10,
// N=1/ACC_W=12) share one stimulus stream. A frame-level model (plain integer
// sum clipped once at frame end) predicts every output each cycle; directed
// sequences add literal expectations.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] in_sum = '0;
    logic       out_ready = 1'b1;

    logic        rdy0, ov0, ovf0;
    logic [11:0] acc0;
    logic [2:0]  cnt0;
    logic        rdy1, ov1, ovf1;
    logic [9:0]  acc1;
    logic [2:0]  cnt1;
    logic        rdy2, ov2, ovf2;
    logic [11:0] acc2;
    logic [0:0]  cnt2;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    sum_accumulator #(.W(8), .N(4), .ACC_W(12)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_sum(in_sum), .in_ready(rdy0), .out_valid(ov0), .out_acc(acc0),
        .out_ovf(ovf0), .out_ready(out_ready), .count(cnt0));

    sum_accumulator #(.W(8), .N(4), .ACC_W(10)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_sum(in_sum), .in_ready(rdy1), .out_valid(ov1), .out_acc(acc1),
        .out_ovf(ovf1), .out_ready(out_ready), .count(cnt1));

    sum_accumulator #(.W(8), .N(1), .ACC_W(12)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_sum(in_sum), .in_ready(rdy2), .out_valid(ov2), .out_acc(acc2),
        .out_ovf(ovf2), .out_ready(out_ready), .count(cnt2));

    // Model: per instance, samples in the frame so far and their exact sum.
    // Clipping non-negative addends step by step equals clipping the exact
    // total once, and the sticky flag equals "exact total exceeded the max".
    int frame_n [3] = '{4, 4, 1};
    int acc_max [3] = '{4095, 1023, 4095};
    int m_cnt   [3];
    int m_sum   [3];
    int m_oacc  [3];
    bit m_oovf  [3];
    bit m_pend  [3];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_cnt[i] = 0; m_sum[i] = 0; m_oacc[i] = 0;
                m_oovf[i] = 1'b0; m_pend[i] = 1'b0;
            end else begin
                bit take;
                take = in_valid && (!m_pend[i] || out_ready) && !clear;
                if (m_pend[i] && out_ready) m_pend[i] = 1'b0;
                if (clear) begin
                    m_cnt[i] = 0; m_sum[i] = 0;
                end else if (take) begin
                    m_sum[i] += int'(in_sum);
                    m_cnt[i]++;
                    if (m_cnt[i] == frame_n[i]) begin
                        m_oacc[i] = (m_sum[i] > acc_max[i]) ? acc_max[i] : m_sum[i];
                        m_oovf[i] = m_sum[i] > acc_max[i];
                        m_pend[i] = 1'b1;
                        m_cnt[i] = 0; m_sum[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic cmp(input int i, input int rdy, input int ov, input int acc,
                       input int ovf, input int cnt);
        check($sformatf("in_ready[%0d]", i), rdy, int'(!m_pend[i] || out_ready));
        check($sformatf("out_valid[%0d]", i), ov, int'(m_pend[i]));
        check($sformatf("out_acc[%0d]", i), acc, m_oacc[i]);
        check($sformatf("out_ovf[%0d]", i), ovf, int'(m_oovf[i]));
        check($sformatf("count[%0d]", i), cnt, m_cnt[i]);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // Per-cycle comparison of all three instances against the model.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            cmp(0, rdy0, ov0, acc0, ovf0, cnt0);
            cmp(1, rdy1, ov1, acc1, ovf1, cnt1);
            cmp(2, rdy2, ov2, acc2, ovf2, cnt2);
        end
    end

    // Present inputs for one rising edge, return just after it.
    task automatic step(input bit v, input int s, input bit clr = 1'b0,
                        input bit rdy = 1'b1, input bit rst = 1'b0);
        in_valid  = v;
        in_sum    = 9'(s);
        clear     = clr;
        out_ready = rdy;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 1, 1);
        armed = 1'b1;
        check("rst out_valid", ov0, 0);
        check("rst out_acc", acc0, 0);
        check("rst out_ovf", ovf0, 0);
        check("rst count", cnt0, 0);
        check("rst in_ready", rdy0, 1);

        // Basic frame 2, 11, 4, 6.
        step(1, 2);  check("basic count1", cnt0, 1);
        step(1, 11); check("basic count2", cnt0, 2);
        step(1, 4);  check("basic count3", cnt0, 3);
        check("basic no valid yet", ov0, 0);
        step(1, 6);
        check("basic count0", cnt0, 0);
        check("basic valid", ov0, 1);
        check("basic acc", acc0, 23);
        check("basic ovf", ovf0, 0);
        step(0, 0);
        check("basic valid pulse", ov0, 0);

        // Saturation on the 10-bit instance.
        for (int k = 0; k < 4; k++) step(1, 510);
        check("sat acc10", acc1, 1023);
        check("sat ovf10", ovf1, 1);
        check("sat acc12", acc0, 2040);
        check("sat ovf12", ovf0, 0);
        check("sat n1 acc", acc2, 510);
        for (int k = 0; k < 4; k++) step(1, 1);
        check("sat next acc", acc1, 4);
        check("sat next ovf", ovf1, 0);
        step(0, 0);

        // Backpressure.
        step(1, 1); step(1, 2); step(1, 3);
        step(1, 4, 0, 0);
        check("bp valid", ov0, 1);
        check("bp acc", acc0, 10);
        for (int k = 0; k < 3; k++) begin
            step(1, 7, 0, 0);
            check("bp in_ready", rdy0, 0);
            check("bp hold acc", acc0, 10);
            check("bp hold count", cnt0, 0);
            check("bp hold valid", ov0, 1);
        end
        step(1, 7, 0, 1);
        check("bp drained", ov0, 0);
        check("bp sample taken", cnt0, 1);

        // Back-to-back frames of 1s.
        step(0, 0, 1, 1);
        for (int k = 1; k <= 8; k++) begin
            step(1, 1);
            check("b2b valid", ov0, int'(k % 4 == 0));
            if (k % 4 == 0) check("b2b acc", acc0, 4);
            check("b2b n1 valid", ov2, 1);
        end

        // Mid-frame abort with clear.
        step(1, 5); step(1, 5);
        step(1, 9, 1);
        check("clear count", cnt0, 0);
        for (int k = 0; k < 4; k++) step(1, 1);
        check("clear acc", acc0, 4);
        check("clear valid", ov0, 1);

        // Mid-frame abort with reset.
        step(1, 5); step(1, 5);
        step(1, 9, 0, 1, 1);
        check("reset valid", ov0, 0);
        check("reset acc", acc0, 0);
        check("reset ovf", ovf0, 0);
        check("reset count", cnt0, 0);
        check("reset n1 acc", acc2, 0);
        check("reset n1 valid", ov2, 0);

        // N = 1 corner.
        step(1, 0);   check("n1 acc0", acc2, 0);   check("n1 valid0", ov2, 1);
        step(1, 511); check("n1 acc511", acc2, 511); check("n1 valid1", ov2, 1);
        step(1, 3);   check("n1 acc3", acc2, 3);   check("n1 ovf", ovf2, 0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? 511 : int'($urandom_range(0, 511)),
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 255) == 0);
        end
        step(0, 0);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
